fifo_flagged: RTL and testbench
===============================

Name: fifo_flagged

Overview:
- Parametrised successor to the basic synchronous FIFO. Adds non-power-of-two depth, an occupancy count, programmable almost-full and almost-empty thresholds, a synchronous flush, and a selectable read mode: first-word-fall-through or registered output.
- Used as the generic buffer between peripherals (UART, timers) and the core bus, where software polls levels and thresholds.

Parameters:
- XLEN, 32, data width in bits (>=1).
- LENGTH, 16, number of entries (>=2; any integer, need not be a power of two).
- AFULL_THRESH, 12, almost_full asserted when count >= AFULL_THRESH (1..LENGTH).
- AEMPTY_THRESH, 4, almost_empty asserted when count <= AEMPTY_THRESH (0..LENGTH-1).
- FWFT, 1, 1 = first-word-fall-through read; 0 = registered read with one-cycle latency.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; empties the FIFO.
- we  in  1  write request.
- re  in  1  read request.
- di  in  XLEN  write data.
- do  out  XLEN  read data.
- rvalid  out  1  do holds valid data.
- empty  out  1  count == 0.
- full  out  1  count == LENGTH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  $clog2(LENGTH+1)  current occupancy.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high.
- Reset values: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0 ? 1 : 0, effectively 0), rvalid=0. In FWFT=0 mode the do register resets to 0. Memory contents are not reset.
- Priority: reset > clear > normal operation.
- clear: same pointer, count and flag effect as reset. Memory is untouched. In FWFT=0, rvalid is cleared but do holds its value. A we or re in the same cycle as clear is dropped.
- Accepted write: we && !full. Stores di at back pointer and advances back pointer.
- Accepted read: re && !empty. Advances front pointer.
- Full and we&re together: only the read is accepted; the write is dropped.
- Empty and we&re together: only the write is accepted; the read is dropped.
- Otherwise we&re together: both are accepted and count is unchanged.
- Pointer wrap: explicit compare; pointer goes LENGTH-1 -> 0. No reliance on natural binary overflow. Pointer width is $clog2(LENGTH).
- count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise. It can never exceed LENGTH or drop below 0.
- Flags: all flags are registered and derived from the next count value, so they are valid in the cycle after the edge that changed count. No combinational path from we/re to any flag.
- FWFT=1:
  - do = memory[front] combinationally.
  - rvalid = !empty.
  - A read consumes the word currently shown on do.
- FWFT=0:
  - On an accepted read, do <= memory[front] at the edge and rvalid=1 for exactly the following cycle.
  - Back-to-back reads give one word per cycle with rvalid held high.
  - A rejected read deasserts rvalid next cycle; do holds its last value.
- Write-then-read latency: a word written at edge N is readable (empty=0) in the cycle after edge N. In FWFT=1 it appears on do in that same cycle.
- Reset or clear mid-operation: in-flight data is discarded and no partial state remains.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, adds two outputs: overflow (1 bit) and underflow (1 bit). Both are sticky.
  - overflow sets on we while full with no accepted read.
  - underflow sets on re while empty.
  - Both are cleared only by reset or clear, and reset to 0.
- When undefined, these ports and their logic do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then idle -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, rvalid=0.
- LENGTH=5, FWFT=1: write 0x11..0x55 (5 words) -> full=1, count=5. Extra write 0x66 is dropped (overflow=1 if enabled). Read 5 -> do sequence 0x11,0x22,0x33,0x44,0x55; then empty=1.
- LENGTH=5: write 3, read 3, repeated 4 times -> pointers wrap past 4 -> 0; data is order-preserved; count never exceeds 3.
- LENGTH=16, AFULL_THRESH=12, AEMPTY_THRESH=4: fill one word per cycle -> almost_empty drops after the 5th write and almost_full rises after the 12th write, each one cycle after the edge.
- FWFT=0: write 0xA, 0xB; assert re 2 cycles -> rvalid=1 with do=0xA, then 0xB one cycle after each read. Simultaneous we(0xC)&re at count=1 -> count stays 1.
- Fill to 7 words, assert clear together with we -> count=0, empty=1, write dropped, overflow/underflow=0. A subsequent write of 0x99 -> do=0x99 (FWFT=1).

Source files
------------

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds, flush and FWFT/registered read.
// Optional sticky overflow/underflow outputs when FIFO_ERR_FLAGS_EN is defined.
module fifo_flagged #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned LENGTH        = 16,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 4,
  parameter bit          FWFT          = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             clear_i,
  input  logic                             we_i,
  input  logic                             re_i,
  input  logic [XLEN-1:0]                  di_i,
  output logic [XLEN-1:0]                  do_o,
  output logic                             rvalid_o,
  output logic                             empty_o,
  output logic                             full_o,
  output logic                             almost_empty_o,
  output logic                             almost_full_o,
  output logic [$clog2(LENGTH+1)-1:0]      count_o
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                             overflow_o,
  output logic                             underflow_o
`endif
);

  localparam int unsigned PW = $clog2(LENGTH);
  localparam int unsigned CW = $clog2(LENGTH + 1);

  logic [XLEN-1:0] mem_q [LENGTH];
  logic [PW-1:0]   front_q, front_d, back_q, back_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, empty_d, full_q, full_d;
  logic            aempty_q, aempty_d, afull_q, afull_d;
  logic            wr_acc, rd_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LENGTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Acceptance, pointer/count update and flags computed from the next count.
  always_comb begin
    wr_acc   = we_i && !full_q && !clear_i && !reset_i;
    rd_acc   = re_i && !empty_q && !clear_i && !reset_i;
    front_d  = front_q;
    back_d   = back_q;
    count_d  = count_q;
    if (clear_i) begin
      front_d = '0;
      back_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) back_d = ptr_inc(back_q);
      if (rd_acc) front_d = ptr_inc(front_q);
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CW'(1);
      end
    end
    empty_d  = (count_d == '0);
    full_d   = (count_d == CW'(LENGTH));
    aempty_d = (count_d <= CW'(AEMPTY_THRESH));
    afull_d  = (count_d >= CW'(AFULL_THRESH));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      front_q  <= '0;
      back_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= (AFULL_THRESH == 0);
    end else begin
      front_q  <= front_d;
      back_q   <= back_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
    end
  end

  // Storage is never reset; only pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[back_q] <= di_i;
  end

  if (FWFT) begin : g_fwft
    assign do_o     = mem_q[front_q];
    assign rvalid_o = !empty_q;
  end else begin : g_reg
    logic [XLEN-1:0] do_q, do_d;
    logic            rvalid_q, rvalid_d;

    always_comb begin
      do_d     = do_q;
      rvalid_d = 1'b0;
      if (rd_acc) begin
        do_d     = mem_q[front_q];
        rvalid_d = 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        do_q     <= '0;
        rvalid_q <= 1'b0;
      end else begin
        do_q     <= do_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign do_o     = do_q;
    assign rvalid_o = rvalid_q;
  end

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = aempty_q;
  assign almost_full_o  = afull_q;
  assign count_o        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // Sticky misuse flags; a write while full is only an error if no read frees a slot.
  always_comb begin
    ovf_d = ovf_q | (we_i && full_q && !rd_acc);
    unf_d = unf_q | (re_i && empty_q);
    if (clear_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`endif

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: three shared-stimulus instances checked against queue models.
// Instances: 0 = LENGTH 5 FWFT, 1 = LENGTH 16 FWFT, 2 = LENGTH 5 registered read.
module tb_fifo_flagged;

  localparam int unsigned XW = 16;
  localparam int unsigned ND = 3;

  logic          clk = 1'b0;
  logic          rst, clr, we, re;
  logic [XW-1:0] di;

  logic [XW-1:0] do_a, do_b, do_c;
  logic          rv_a, rv_b, rv_c, em_a, em_b, em_c, fu_a, fu_b, fu_c;
  logic          ae_a, ae_b, ae_c, af_a, af_b, af_c;
  logic [2:0]    cnt_a, cnt_c;
  logic [4:0]    cnt_b;
`ifdef FIFO_ERR_FLAGS_EN
  logic          ov_a, ov_b, ov_c, un_a, un_b, un_c;
`endif

  always #5 clk = ~clk;

  fifo_flagged #(.XLEN(XW), .LENGTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(1'b1)) u_a (
    .clk_i(clk), .reset_i(rst), .clear_i(clr), .we_i(we), .re_i(re), .di_i(di),
    .do_o(do_a), .rvalid_o(rv_a), .empty_o(em_a), .full_o(fu_a),
    .almost_empty_o(ae_a), .almost_full_o(af_a), .count_o(cnt_a)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow_o(ov_a), .underflow_o(un_a)
`endif
  );

  fifo_flagged #(.XLEN(XW), .LENGTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1'b1)) u_b (
    .clk_i(clk), .reset_i(rst), .clear_i(clr), .we_i(we), .re_i(re), .di_i(di),
    .do_o(do_b), .rvalid_o(rv_b), .empty_o(em_b), .full_o(fu_b),
    .almost_empty_o(ae_b), .almost_full_o(af_b), .count_o(cnt_b)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow_o(ov_b), .underflow_o(un_b)
`endif
  );

  fifo_flagged #(.XLEN(XW), .LENGTH(5), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1'b0)) u_c (
    .clk_i(clk), .reset_i(rst), .clear_i(clr), .we_i(we), .re_i(re), .di_i(di),
    .do_o(do_c), .rvalid_o(rv_c), .empty_o(em_c), .full_o(fu_c),
    .almost_empty_o(ae_c), .almost_full_o(af_c), .count_o(cnt_c)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow_o(ov_c), .underflow_o(un_c)
`endif
  );

  // Observed outputs gathered per instance for indexed checking.
  logic [31:0] o_cnt [ND];
  logic [31:0] o_do  [ND];
  logic        o_rv [ND], o_em [ND], o_fu [ND], o_ae [ND], o_af [ND];
  logic        o_ov [ND], o_un [ND];

  always_comb begin
    o_cnt[0] = 32'(cnt_a); o_cnt[1] = 32'(cnt_b); o_cnt[2] = 32'(cnt_c);
    o_do[0]  = 32'(do_a);  o_do[1]  = 32'(do_b);  o_do[2]  = 32'(do_c);
    o_rv[0] = rv_a; o_rv[1] = rv_b; o_rv[2] = rv_c;
    o_em[0] = em_a; o_em[1] = em_b; o_em[2] = em_c;
    o_fu[0] = fu_a; o_fu[1] = fu_b; o_fu[2] = fu_c;
    o_ae[0] = ae_a; o_ae[1] = ae_b; o_ae[2] = ae_c;
    o_af[0] = af_a; o_af[1] = af_b; o_af[2] = af_c;
`ifdef FIFO_ERR_FLAGS_EN
    o_ov[0] = ov_a; o_ov[1] = ov_b; o_ov[2] = ov_c;
    o_un[0] = un_a; o_un[1] = un_b; o_un[2] = un_c;
`else
    for (int k = 0; k < int'(ND); k++) begin
      o_ov[k] = 1'b0;
      o_un[k] = 1'b0;
    end
`endif
  end

  function automatic int len_of(input int k);
    return (k == 1) ? 16 : 5;
  endfunction
  function automatic int af_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 12 : 3);
  endfunction
  function automatic int ae_of(input int k);
    return (k == 1) ? 4 : 1;
  endfunction
  function automatic bit fwft_of(input int k);
    return (k != 2);
  endfunction

  // Reference model: plain queue of stored words per instance.
  logic [XW-1:0] mq [ND][$];
  logic [XW-1:0] m_do [ND];
  bit            m_rv [ND], m_ov [ND], m_un [ND];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < int'(ND); k++) begin
      int sz;
      bit is_full, is_empty, wacc, racc;
      sz       = mq[k].size();
      is_full  = (sz == len_of(k));
      is_empty = (sz == 0);
      if (rst || clr) begin
        mq[k].delete();
        m_rv[k] = 1'b0;
        m_ov[k] = 1'b0;
        m_un[k] = 1'b0;
        if (rst) m_do[k] = '0;
      end else begin
        wacc = we && !is_full;
        racc = re && !is_empty;
        if (we && is_full && !racc) m_ov[k] = 1'b1;
        if (re && is_empty) m_un[k] = 1'b1;
        m_rv[k] = 1'b0;
        if (racc) begin
          m_do[k] = mq[k].pop_front();
          m_rv[k] = 1'b1;
        end
        if (wacc) mq[k].push_back(di);
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < int'(ND); k++) begin
      int sz;
      sz = mq[k].size();
      check_eq($sformatf("d%0d_count", k), o_cnt[k], 32'(sz));
      check_eq($sformatf("d%0d_empty", k), 32'(o_em[k]), 32'(sz == 0));
      check_eq($sformatf("d%0d_full", k), 32'(o_fu[k]), 32'(sz == len_of(k)));
      check_eq($sformatf("d%0d_aempty", k), 32'(o_ae[k]), 32'(sz <= ae_of(k)));
      check_eq($sformatf("d%0d_afull", k), 32'(o_af[k]), 32'(sz >= af_of(k)));
      if (fwft_of(k)) begin
        check_eq($sformatf("d%0d_rvalid", k), 32'(o_rv[k]), 32'(sz != 0));
        if (sz != 0) check_eq($sformatf("d%0d_do", k), o_do[k], 32'(mq[k][0]));
      end else begin
        check_eq($sformatf("d%0d_rvalid", k), 32'(o_rv[k]), 32'(m_rv[k]));
        check_eq($sformatf("d%0d_do", k), o_do[k], 32'(m_do[k]));
      end
`ifdef FIFO_ERR_FLAGS_EN
      check_eq($sformatf("d%0d_overflow", k), 32'(o_ov[k]), 32'(m_ov[k]));
      check_eq($sformatf("d%0d_underflow", k), 32'(o_un[k]), 32'(m_un[k]));
`endif
    end
  endtask

  task automatic cycle(input bit w, input bit r, input logic [XW-1:0] d, input bit c, input bit rs);
    we = w; re = r; di = d; clr = c; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; di = '0;
    for (int i = 0; i < int'(ND); i++) begin
      m_do[i] = '0; m_rv[i] = 1'b0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
    end

    // Reset then idle.
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("rst_empty", 32'(em_a), 32'(1));
    check_eq("rst_full", 32'(fu_a), 32'(0));
    check_eq("rst_count", 32'(cnt_b), 32'(0));
    check_eq("rst_aempty", 32'(ae_b), 32'(1));
    check_eq("rst_afull", 32'(af_b), 32'(0));
    check_eq("rst_rvalid", 32'(rv_c), 32'(0));
    check_eq("rst_do_reg", 32'(do_c), 32'(0));

    // Fill LENGTH=5, extra write dropped, drain in order.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, XW'(i * 'h11), 1'b0, 1'b0);
    check_eq("fill_full", 32'(fu_a), 32'(1));
    check_eq("fill_count", 32'(cnt_a), 32'(5));
    cycle(1'b1, 1'b0, XW'('h66), 1'b0, 1'b0);
    check_eq("drop_count", 32'(cnt_a), 32'(5));
    check_eq("deep_count", 32'(cnt_b), 32'(6));
    for (int i = 1; i <= 5; i++) begin
      check_eq("fwft_do_seq", 32'(do_a), 32'(i * 'h11));
      cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      check_eq("reg_do_seq", 32'(do_c), 32'(i * 'h11));
    end
    check_eq("drain_empty", 32'(em_a), 32'(1));

    // Pointer wrap: 3 in, 3 out, four rounds.
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int j = 1; j <= 3; j++) cycle(1'b1, 1'b0, XW'(r * 16 + j), 1'b0, 1'b0);
      check_eq("wrap_cnt", 32'(cnt_a), 32'(3));
      for (int j = 1; j <= 3; j++) begin
        check_eq("wrap_do", 32'(do_a), 32'(r * 16 + j));
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      end
    end

    // Threshold crossings on the 16-deep instance.
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, XW'(i + 'h100), 1'b0, 1'b0);
      check_eq("thr_aempty", 32'(ae_b), 32'(i <= 4));
      check_eq("thr_afull", 32'(af_b), 32'(i >= 12));
    end

    // Registered read mode: A,B then read, then read with simultaneous write.
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, XW'('hA), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, XW'('hB), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    check_eq("reg_rv1", 32'(rv_c), 32'(1));
    check_eq("reg_doA", 32'(do_c), 32'('hA));
    cycle(1'b1, 1'b1, XW'('hC), 1'b0, 1'b0);
    check_eq("reg_rv2", 32'(rv_c), 32'(1));
    check_eq("reg_doB", 32'(do_c), 32'('hB));
    check_eq("reg_cnt_same", 32'(cnt_c), 32'(1));
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("reg_rv_drop", 32'(rv_c), 32'(0));
    check_eq("reg_do_hold", 32'(do_c), 32'('hB));

    // Clear with a concurrent write, then a fresh write.
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, XW'(i + 'h70), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, XW'('h77), 1'b1, 1'b0);
    check_eq("clr_count", 32'(cnt_b), 32'(0));
    check_eq("clr_empty", 32'(em_b), 32'(1));
    cycle(1'b1, 1'b0, XW'('h99), 1'b0, 1'b0);
    check_eq("post_clr_do", 32'(do_a), 32'('h99));
    check_eq("post_clr_cnt", 32'(cnt_b), 32'(1));

    // Randomized traffic with phases biased toward filling and draining.
    for (int n = 0; n < 3000; n++) begin
      int wp;
      wp = ((n / 300) % 2 == 0) ? 70 : 30;
      cycle(bit'($urandom_range(0, 99) < 32'(wp)),
            bit'($urandom_range(0, 99) < 32'(100 - wp)),
            XW'($urandom),
            bit'($urandom_range(0, 99) == 0),
            bit'($urandom_range(0, 499) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
